cacheline_burst_adaptor: RTL and testbench



---
 rtl/cacheline_burst_adaptor_if.sv | 33 +++
 rtl/cacheline_burst_adaptor.sv | 144 ++++++++++++++
 tb/tb_cacheline_burst_adaptor.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/cacheline_burst_adaptor_if.sv
// Bus bundle for cacheline_burst_adaptor: the line-side request/response
// from the cache arbiter and the beat-side physical memory port.
// The slave modport is the adaptor's view. The master modport is the view
// of whoever drives the arbiter requests and plays the memory.
interface cacheline_burst_adaptor_if;
  logic         mem_read;
  logic         mem_write;
  logic [31:0]  mem_address;
  logic [255:0] mem_wdata;
  logic [255:0] mem_rdata;
  logic         mem_resp;

  logic         pmem_read;
  logic         pmem_write;
  logic [31:0]  pmem_address;
  logic [63:0]  pmem_wdata;
  logic [63:0]  pmem_rdata;
  logic         pmem_resp;

  modport master (
    output mem_read, mem_write, mem_address, mem_wdata,
    output pmem_rdata, pmem_resp,
    input  mem_rdata, mem_resp,
    input  pmem_read, pmem_write, pmem_address, pmem_wdata
  );

  modport slave (
    input  mem_read, mem_write, mem_address, mem_wdata,
    input  pmem_rdata, pmem_resp,
    output mem_rdata, mem_resp,
    output pmem_read, pmem_write, pmem_address, pmem_wdata
  );
endinterface

// File: rtl/cacheline_burst_adaptor.sv
// cacheline_burst_adaptor: splits one 256-bit line transfer into four 64-bit
// beats on the physical memory port and reassembles read beats into a line.
// Beat 0 is line bits [63:0]. Only one line transaction is in flight at a time.
//
// Build option: define ADAPTOR_ADDR_ALIGN_EN to force pmem_address to a
// 32-byte line boundary. Without the macro, the captured address passes
// through unchanged.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | waiting for mem_read / mem_write (read wins)
// READ  | pmem_read high, collecting 4 beats into the line register
// WRITE | pmem_write high, presenting 4 beats from the write buffer
// DONE  | one-cycle mem_resp; held requests are not re-accepted here
module cacheline_burst_adaptor (
  input  logic                        clk,
  input  logic                        rst,
  cacheline_burst_adaptor_if.slave    bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t       state;
  state_t       state_n;

  logic [1:0]   cnt;
  logic [1:0]   cnt_inc;
  logic [255:0] wbuf;
  logic [255:0] rdata_q;
  logic         resp_q;
  logic         pread_q;
  logic         pwrite_q;
  logic [31:0]  paddr_q;
  logic [63:0]  pwdata_q;
  logic [31:0]  addr_sel;

  logic         accept_rd;
  logic         accept_wr;
  logic         beat;

`ifdef ADAPTOR_ADDR_ALIGN_EN
  assign addr_sel = {bus.mem_address[31:5], 5'b0};
`else
  assign addr_sel = bus.mem_address;
`endif

  assign cnt_inc = cnt + 2'd1;

  // Next-state decode plus the acceptance and beat strobes used by the datapath
  always_comb begin
    state_n   = state;
    accept_rd = 1'b0;
    accept_wr = 1'b0;
    beat      = 1'b0;
    case (state)
      IDLE: begin
        if (bus.mem_read) begin
          accept_rd = 1'b1;
          state_n   = READ;
        end else if (bus.mem_write) begin
          accept_wr = 1'b1;
          state_n   = WRITE;
        end
      end
      READ, WRITE: begin
        if (bus.pmem_resp) begin
          beat = 1'b1;
          if (cnt == 2'd3) begin
            state_n = DONE;
          end
        end
      end
      DONE: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  // Registered outputs, beat counter, write buffer and read-line assembly
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt      <= 2'd0;
      wbuf     <= '0;
      rdata_q  <= '0;
      resp_q   <= 1'b0;
      pread_q  <= 1'b0;
      pwrite_q <= 1'b0;
      paddr_q  <= '0;
      pwdata_q <= '0;
    end else begin
      // Strobes follow the next state so that they come straight from flops
      // and line up with the state they belong to.
      resp_q   <= (state_n == DONE);
      pread_q  <= (state_n == READ);
      pwrite_q <= (state_n == WRITE);

      if (accept_rd || accept_wr) begin
        cnt     <= 2'd0;
        paddr_q <= addr_sel;
      end

      if (accept_wr) begin
        wbuf     <= bus.mem_wdata;
        pwdata_q <= bus.mem_wdata[63:0];
      end

      if (beat) begin
        cnt <= cnt_inc;
        if (state == READ) begin
          rdata_q[{cnt, 6'b0} +: 64] <= bus.pmem_rdata;
        end
        // After the final beat the last word is held, not wrapped to beat 0.
        if ((state == WRITE) && (cnt != 2'd3)) begin
          pwdata_q <= wbuf[{cnt_inc, 6'b0} +: 64];
        end
      end
    end
  end

  assign bus.mem_rdata    = rdata_q;
  assign bus.mem_resp     = resp_q;
  assign bus.pmem_read    = pread_q;
  assign bus.pmem_write   = pwrite_q;
  assign bus.pmem_address = paddr_q;
  assign bus.pmem_wdata   = pwdata_q;

endmodule

// File: tb/tb_cacheline_burst_adaptor.sv
// Directed bench for cacheline_burst_adaptor. Inputs change and outputs are
// sampled on the falling edge. Cycle numbering starts at 0 for the cycle
// in which a request is presented.
module tb_cacheline_burst_adaptor;
  logic clk;
  logic rst;
  int   checks;
  int   failures;

  cacheline_burst_adaptor_if bus();

  cacheline_burst_adaptor dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] exp_addr(input logic [31:0] a);
`ifdef ADAPTOR_ADDR_ALIGN_EN
    return {a[31:5], 5'b0};
`else
    return a;
`endif
  endfunction

  // Full read with four back-to-back beats, starting at a falling edge in IDLE.
  task automatic run_read(input string tag, input logic [31:0] addr, input logic [255:0] line);
    bus.mem_read    = 1'b1;
    bus.mem_address = addr;
    @(negedge clk);
    chk({tag, "_paddr"}, {224'b0, bus.pmem_address}, {224'b0, exp_addr(addr)});
    for (int b = 0; b < 4; b++) begin
      chk($sformatf("%s_pread_b%0d", tag, b), {255'b0, bus.pmem_read}, 256'd1);
      chk($sformatf("%s_resp_b%0d", tag, b), {255'b0, bus.mem_resp}, 256'd0);
      bus.pmem_resp  = 1'b1;
      bus.pmem_rdata = line[b*64 +: 64];
      @(negedge clk);
    end
    bus.pmem_resp = 1'b0;
    chk({tag, "_resp_c5"}, {255'b0, bus.mem_resp}, 256'd1);
    chk({tag, "_rdata"}, bus.mem_rdata, line);
    chk({tag, "_pread_c5"}, {255'b0, bus.pmem_read}, 256'd0);
    bus.mem_read = 1'b0;
    @(negedge clk);
    chk({tag, "_resp_c6"}, {255'b0, bus.mem_resp}, 256'd0);
  endtask

  logic [255:0] line_a;
  logic [255:0] line_g;
  logic [255:0] line_w;
  logic [6:0]   gap_pat;
  int           gap_beat;

  initial begin
    checks          = 0;
    failures        = 0;
    rst             = 1'b1;
    bus.mem_read    = 1'b0;
    bus.mem_write   = 1'b0;
    bus.mem_address = '0;
    bus.mem_wdata   = '0;
    bus.pmem_rdata  = '0;
    bus.pmem_resp   = 1'b0;

    // Reset state
    @(negedge clk);
    @(negedge clk);
    chk("rst_mem_resp", {255'b0, bus.mem_resp}, 256'd0);
    chk("rst_pread", {255'b0, bus.pmem_read}, 256'd0);
    chk("rst_pwrite", {255'b0, bus.pmem_write}, 256'd0);
    chk("rst_paddr", {224'b0, bus.pmem_address}, 256'd0);
    chk("rst_pwdata", {192'b0, bus.pmem_wdata}, 256'd0);
    chk("rst_rdata", bus.mem_rdata, 256'd0);
    rst = 1'b0;
    @(negedge clk);

    // Basic read
    line_a = {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
              64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111};
    run_read("rd", 32'h0000_1064, line_a);

    // Write; the address and data change after acceptance must not leak through
    line_w = {64'hDDDD_DDDD_DDDD_DDDD, 64'hCCCC_CCCC_CCCC_CCCC,
              64'hBBBB_BBBB_BBBB_BBBB, 64'hAAAA_AAAA_AAAA_AAAA};
    bus.mem_write   = 1'b1;
    bus.mem_address = 32'h0000_3018;
    bus.mem_wdata   = line_w;
    @(negedge clk);
    bus.mem_address = 32'hFFFF_FFFF;
    bus.mem_wdata   = '1;
    chk("wr_paddr", {224'b0, bus.pmem_address}, {224'b0, exp_addr(32'h0000_3018)});
    chk("wr_pread", {255'b0, bus.pmem_read}, 256'd0);
    for (int b = 0; b < 4; b++) begin
      chk($sformatf("wr_pwrite_b%0d", b), {255'b0, bus.pmem_write}, 256'd1);
      chk($sformatf("wr_pwdata_b%0d", b), {192'b0, bus.pmem_wdata}, {192'b0, line_w[b*64 +: 64]});
      chk($sformatf("wr_resp_b%0d", b), {255'b0, bus.mem_resp}, 256'd0);
      bus.pmem_resp = 1'b1;
      @(negedge clk);
    end
    bus.pmem_resp = 1'b0;
    bus.mem_write = 1'b0;
    chk("wr_pwrite_c5", {255'b0, bus.pmem_write}, 256'd0);
    chk("wr_resp_c5", {255'b0, bus.mem_resp}, 256'd1);
    chk("wr_rdata_kept", bus.mem_rdata, line_a);
    @(negedge clk);
    chk("wr_resp_c6", {255'b0, bus.mem_resp}, 256'd0);

    // Gapped read: pmem_resp 1,0,0,1,1,0,1 in cycles 1..7, mem_resp in cycle 8
    line_g  = {64'h0404_0404_0404_0404, 64'h0303_0303_0303_0303,
               64'h0202_0202_0202_0202, 64'h0101_0101_0101_0101};
    gap_pat = 7'b1011001;
    gap_beat = 0;
    bus.mem_read    = 1'b1;
    bus.mem_address = 32'h0000_2040;
    @(negedge clk);
    for (int i = 0; i < 7; i++) begin
      chk($sformatf("gap_pread_c%0d", i + 1), {255'b0, bus.pmem_read}, 256'd1);
      chk($sformatf("gap_resp_c%0d", i + 1), {255'b0, bus.mem_resp}, 256'd0);
      chk($sformatf("gap_paddr_c%0d", i + 1), {224'b0, bus.pmem_address},
          {224'b0, exp_addr(32'h0000_2040)});
      bus.pmem_resp = gap_pat[i];
      if (gap_pat[i]) begin
        bus.pmem_rdata = line_g[gap_beat*64 +: 64];
        gap_beat++;
      end else begin
        bus.pmem_rdata = 64'hBAD0_BAD0_BAD0_BAD0;
      end
      @(negedge clk);
    end
    bus.pmem_resp = 1'b0;
    bus.mem_read  = 1'b0;
    chk("gap_resp_c8", {255'b0, bus.mem_resp}, 256'd1);
    chk("gap_rdata", bus.mem_rdata, line_g);
    chk("gap_pread_c8", {255'b0, bus.pmem_read}, 256'd0);
    @(negedge clk);
    chk("gap_resp_c9", {255'b0, bus.mem_resp}, 256'd0);

    // Back-to-back: mem_read held through DONE, new address presented in cycle 6
    bus.mem_read    = 1'b1;
    bus.mem_address = 32'h0000_4000;
    @(negedge clk);
    for (int b = 0; b < 4; b++) begin
      bus.pmem_resp  = 1'b1;
      bus.pmem_rdata = line_a[b*64 +: 64];
      @(negedge clk);
    end
    bus.pmem_resp = 1'b0;
    chk("b2b_resp_c5", {255'b0, bus.mem_resp}, 256'd1);
    @(negedge clk);
    chk("b2b_resp_c6", {255'b0, bus.mem_resp}, 256'd0);
    chk("b2b_pread_c6", {255'b0, bus.pmem_read}, 256'd0);
    bus.mem_address = 32'h0000_5020;
    @(negedge clk);
    chk("b2b_pread_c7", {255'b0, bus.pmem_read}, 256'd1);
    chk("b2b_paddr_c7", {224'b0, bus.pmem_address}, {224'b0, exp_addr(32'h0000_5020)});
    chk("b2b_resp_c7", {255'b0, bus.mem_resp}, 256'd0);
    for (int b = 0; b < 4; b++) begin
      bus.pmem_resp  = 1'b1;
      bus.pmem_rdata = line_g[b*64 +: 64];
      @(negedge clk);
    end
    bus.pmem_resp = 1'b0;
    bus.mem_read  = 1'b0;
    chk("b2b_resp_2nd", {255'b0, bus.mem_resp}, 256'd1);
    chk("b2b_rdata_2nd", bus.mem_rdata, line_g);
    @(negedge clk);
    chk("b2b_resp_after", {255'b0, bus.mem_resp}, 256'd0);

    // Simultaneous read and write: read burst only
    bus.mem_write = 1'b1;
    bus.mem_wdata = line_w;
    run_read("both", 32'h0000_6000, line_a);
    bus.mem_write = 1'b0;
    chk("both_pwrite", {255'b0, bus.pmem_write}, 256'd0);

    // Stray pmem_resp in IDLE
    bus.pmem_resp  = 1'b1;
    bus.pmem_rdata = 64'hFEED_FEED_FEED_FEED;
    @(negedge clk);
    @(negedge clk);
    chk("stray_pread", {255'b0, bus.pmem_read}, 256'd0);
    chk("stray_pwrite", {255'b0, bus.pmem_write}, 256'd0);
    chk("stray_resp", {255'b0, bus.mem_resp}, 256'd0);
    chk("stray_rdata", bus.mem_rdata, line_a);
    bus.pmem_resp = 1'b0;
    @(negedge clk);

    // Reset after beat 2 of a read
    bus.mem_read    = 1'b1;
    bus.mem_address = 32'h0000_7000;
    @(negedge clk);
    bus.pmem_resp  = 1'b1;
    bus.pmem_rdata = line_g[63:0];
    @(negedge clk);
    bus.pmem_rdata = line_g[127:64];
    @(negedge clk);
    bus.pmem_resp = 1'b0;
    bus.mem_read  = 1'b0;
    rst = 1'b1;
    #1;
    chk("mrst_pread", {255'b0, bus.pmem_read}, 256'd0);
    chk("mrst_resp", {255'b0, bus.mem_resp}, 256'd0);
    chk("mrst_paddr", {224'b0, bus.pmem_address}, 256'd0);
    chk("mrst_rdata", bus.mem_rdata, 256'd0);
    chk("mrst_pwdata", {192'b0, bus.pmem_wdata}, 256'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("mrst_resp_after", {255'b0, bus.mem_resp}, 256'd0);
    chk("mrst_pread_after", {255'b0, bus.pmem_read}, 256'd0);
    run_read("post_rst", 32'h0000_1064, line_g);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
